// File: rtl/bit_serial_alu_sequencer.sv
// Bit-serial sequencer driving a single external one-bit ALU slice.
// Ports: clk/rst, start/op/a_in/b_in request; busy/done/result/zero/
// overflow/cout/err status; slice_* drive to the slice and its outputs back.
module bit_serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             err,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_next;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cin_msb;
    logic             cout_msb;
    logic             set_msb;
    logic             legal;
    logic             last;
    logic             lt;

    assign legal = (op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
    assign last  = (idx == LAST);
    // Sign of a-b corrected for signed overflow at the MSB.
    assign lt    = set_msb ^ cin_msb ^ cout_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        slice_op   = 3'b000;
        res_next   = result;
        unique case (state)
            IDLE: begin
                if (start) begin
                    res_next   = '0;
                    state_next = legal ? RUN : DONE;
                end
            end
            RUN: begin
                busy          = 1'b1;
                slice_a       = a_q[idx];
                slice_b       = b_q[idx];
                slice_cin     = carry;
                slice_op      = op_q;
                res_next[idx] = slice_result;
                if (last) begin
                    state_next = (op_q == 3'b111) ? SLT_FIX : DONE;
                end
            end
            SLT_FIX: begin
                busy        = 1'b1;
                slice_a     = a_q[0];
                slice_b     = b_q[0];
                slice_cin   = 1'b1;
                slice_less  = lt;
                slice_op    = 3'b111;
                res_next[0] = slice_result;
                state_next  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            idx      <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            set_msb  <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            cout     <= 1'b0;
            err      <= 1'b0;
        end else begin
            result <= res_next;
            // Flag tracks the value the result will hold while done is high.
            if (state_next == DONE && state != DONE) begin
                zero <= (res_next == '0);
            end
            unique case (state)
                IDLE: begin
                    if (start && legal) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        op_q  <= op;
                        carry <= op[2];
                        idx   <= '0;
                        err   <= 1'b0;
                    end else if (start) begin
                        overflow <= 1'b0;
                        cout     <= 1'b0;
                        err      <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= slice_cout;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cin_msb  <= carry;
                        cout_msb <= slice_cout;
                        set_msb  <= slice_set;
                        if (op_q[1] && !op_q[0]) begin
                            overflow <= carry ^ slice_cout;
                            cout     <= slice_cout;
                        end else begin
                            overflow <= 1'b0;
                            cout     <= 1'b0;
                        end
                    end
                end
                SLT_FIX: begin
                    overflow <= 1'b0;
                    cout     <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
